cache_mem_arbiter: RTL and testbench

- Sits directly downstream of the instruction cache and alongside the data cache.
- Arbitrates the icache miss-fill port (iREN/iaddr) and the dcache port (dREN/dWEN/daddr/dstore) onto a single shared RAM port.
- Returns iload/iwait and dload/dwait to the caches.
- Data side has priority; a bounded anti-starvation counter guarantees instruction fills progress.

---
 rtl/cache_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Cache-to-memory arbiter: merges the icache fill port and the dcache port
// onto one shared RAM port. The data side normally wins; a saturating
// starve counter forces an instruction grant after STARVE_MAX consecutive
// data completions that left an instruction request waiting.
module cache_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    // icache side
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    // dcache side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    // shared RAM port
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;

    logic d_req;
    logic ram_done;

    assign d_req    = dREN | dWEN;
    assign ram_done = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);

    // State and starve counter; reset drops any in-flight transfer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Grant decision, RAM port steering and completion signalling.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        mem_err  = 1'b0;

        case (state_q)
            IDLE: begin
                // Data wins unless the instruction side has been starved long enough.
                if (iREN && (!d_req || (starve_q >= STARVE_LIM))) begin
                    state_d = SERVE_I;
                end else if (d_req) begin
                    state_d = SERVE_D;
                end
            end

            SERVE_D: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    // Request withdrawn: abandon without a completion pulse.
                    state_d = IDLE;
                end else if (ram_done) begin
                    dwait   = 1'b0;
                    state_d = IDLE;
                    if (ramstate == RAM_ERROR) begin
                        mem_err = 1'b1;
                    end else if (dREN) begin
                        dload = ramload;
                    end
                    // Count data wins that happened while an ifetch was waiting.
                    if (iREN) begin
                        if (starve_q < STARVE_LIM) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        starve_d = 4'd0;
                    end
                end
            end

            SERVE_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_done) begin
                    iwait    = 1'b0;
                    state_d  = IDLE;
                    starve_d = 4'd0;
                    if (ramstate == RAM_ERROR) begin
                        mem_err = 1'b1;
                    end else begin
                        iload = ramload;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed vector bench for cache_mem_arbiter: one table row per clock cycle,
// plus a hand-written asynchronous-reset sequence.
module tb_cache_mem_arbiter;

    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        logic [1:0]  rstate;
    } in_t;

    typedef struct packed {
        logic        iwait;
        logic [31:0] iload;
        logic        dwait;
        logic [31:0] dload;
        logic        ren;
        logic        wen;
        logic [31:0] raddr;
        logic [31:0] rstore;
        logic        err;
    } out_t;

    typedef struct {
        in_t  in;
        out_t ex;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    cache_mem_arbiter #(.STARVE_MAX(4), .ADDR_W(32), .WORD_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .mem_err  (mem_err)
    );

    always #5 CLK = ~CLK;

    function automatic in_t mi(logic ir, logic [31:0] ia, logic dr, logic dw,
                               logic [31:0] da, logic [31:0] ds,
                               logic [31:0] rl, logic [1:0] rs);
        in_t v;
        v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw;
        v.daddr = da; v.dstore = ds; v.ramload = rl; v.rstate = rs;
        return v;
    endfunction

    // Idle / reset view of all outputs.
    function automatic out_t idle_o();
        out_t o;
        o = '0;
        o.iwait = 1'b1;
        o.dwait = 1'b1;
        return o;
    endfunction

    // Data side granted.
    function automatic out_t d_o(logic ren, logic wen, logic [31:0] a, logic [31:0] s,
                                 logic dw, logic [31:0] dl, logic e);
        out_t o;
        o = idle_o();
        o.ren = ren; o.wen = wen; o.raddr = a; o.rstore = s;
        o.dwait = dw; o.dload = dl; o.err = e;
        return o;
    endfunction

    // Instruction side granted.
    function automatic out_t i_o(logic [31:0] a, logic iw, logic [31:0] il, logic e);
        out_t o;
        o = idle_o();
        o.ren = 1'b1; o.raddr = a;
        o.iwait = iw; o.iload = il; o.err = e;
        return o;
    endfunction

    task automatic drive(input in_t v);
        iREN = v.iren; iaddr = v.iaddr; dREN = v.dren; dWEN = v.dwen;
        daddr = v.daddr; dstore = v.dstore; ramload = v.ramload; ramstate = v.rstate;
    endtask

    task automatic check(input string name, input out_t ex);
        out_t act;
        act = '{iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err};
        n_vec++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s t=%0t got iw=%b il=%h dw=%b dl=%h ren=%b wen=%b ra=%h rs=%h err=%b need iw=%b il=%h dw=%b dl=%h ren=%b wen=%b ra=%h rs=%h err=%b",
                     name, $time, act.iwait, act.iload, act.dwait, act.dload, act.ren, act.wen,
                     act.raddr, act.rstore, act.err, ex.iwait, ex.iload, ex.dwait, ex.dload,
                     ex.ren, ex.wen, ex.raddr, ex.rstore, ex.err);
        end else begin
            $display("ok   %s t=%0t ren=%b wen=%b ra=%h iw=%b dw=%b err=%b",
                     name, $time, act.ren, act.wen, act.raddr, act.iwait, act.dwait, act.err);
        end
    endtask

    // One cycle: drive just after the edge, sample at the falling edge.
    task automatic step(input string name, input in_t v, input out_t ex);
        drive(v);
        @(negedge CLK);
        check(name, ex);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        in_t v;

        // ---- instruction fill, ACCESS on first serve cycle ----
        tbl.push_back('{mi(1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, ACC), idle_o()});
        tbl.push_back('{mi(1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, ACC), i_o(32'h40, 0, 32'hDEADBEEF, 0)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 32'hDEADBEEF, ACC), idle_o()});
        // ---- simultaneous requests: data first, then instruction ----
        tbl.push_back('{mi(1, 32'h44, 1, 0, 32'h80, 32'h5555, 32'h1111_1111, FREE), idle_o()});
        tbl.push_back('{mi(1, 32'h44, 1, 0, 32'h80, 32'h5555, 32'h1111_1111, ACC),
                        d_o(1, 0, 32'h80, 32'h5555, 0, 32'h1111_1111, 0)});
        tbl.push_back('{mi(1, 32'h44, 0, 0, 32'h80, 32'h5555, 32'h1111_1111, ACC), idle_o()});
        tbl.push_back('{mi(1, 32'h44, 0, 0, 0, 0, 32'h2222_2222, ACC), i_o(32'h44, 0, 32'h2222_2222, 0)});
        // ---- starvation: four data writes, then a forced instruction grant ----
        for (int k = 0; k < 4; k++) begin
            tbl.push_back('{mi(1, 32'h48, 0, 1, 32'h100 + k, 32'hA000 + k, 32'h3333_3333, ACC), idle_o()});
            tbl.push_back('{mi(1, 32'h48, 0, 1, 32'h100 + k, 32'hA000 + k, 32'h3333_3333, ACC),
                            d_o(0, 1, 32'h100 + k, 32'hA000 + k, 0, 0, 0)});
        end
        tbl.push_back('{mi(1, 32'h48, 0, 1, 32'h104, 32'hA004, 32'h3333_3333, ACC), idle_o()});
        tbl.push_back('{mi(1, 32'h48, 0, 1, 32'h104, 32'hA004, 32'h3333_3333, ACC),
                        i_o(32'h48, 0, 32'h3333_3333, 0)});
        // counter cleared by the instruction completion, so data wins again
        tbl.push_back('{mi(1, 32'h48, 0, 1, 32'h104, 32'hA004, 32'h3333_3333, ACC), idle_o()});
        tbl.push_back('{mi(1, 32'h48, 0, 1, 32'h104, 32'hA004, 32'h3333_3333, ACC),
                        d_o(0, 1, 32'h104, 32'hA004, 0, 0, 0)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, FREE), idle_o()});
        // ---- BUSY x3 then ACCESS on a data read ----
        tbl.push_back('{mi(0, 0, 1, 0, 32'h200, 0, 32'h4444_4444, BUSY), idle_o()});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{mi(0, 0, 1, 0, 32'h200, 0, 32'h4444_4444, BUSY), d_o(1, 0, 32'h200, 0, 1, 0, 0)});
        tbl.push_back('{mi(0, 0, 1, 0, 32'h200, 0, 32'h4444_4444, ACC),
                        d_o(1, 0, 32'h200, 0, 0, 32'h4444_4444, 0)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, FREE), idle_o()});
        // ---- ERROR on an instruction fill ----
        tbl.push_back('{mi(1, 32'h300, 0, 0, 0, 0, 32'h5555_5555, ERR), idle_o()});
        tbl.push_back('{mi(1, 32'h300, 0, 0, 0, 0, 32'h5555_5555, ERR), i_o(32'h300, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 32'h5555_5555, ERR), idle_o()});
        // ---- data request withdrawn mid-transfer ----
        tbl.push_back('{mi(0, 0, 1, 0, 32'h400, 32'h66, 32'h7777, BUSY), idle_o()});
        tbl.push_back('{mi(0, 0, 0, 0, 32'h400, 32'h66, 32'h7777, ACC), d_o(0, 0, 32'h400, 32'h66, 1, 0, 0)});
        tbl.push_back('{mi(0, 0, 1, 0, 32'h400, 32'h66, 32'h7777, ACC), idle_o()});
        tbl.push_back('{mi(0, 0, 1, 0, 32'h400, 32'h66, 32'h7777, ACC), d_o(1, 0, 32'h400, 32'h66, 0, 32'h7777, 0)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, FREE), idle_o()});
        // ---- ERROR on a data write ----
        tbl.push_back('{mi(0, 0, 0, 1, 32'h500, 32'h88, 32'h9999, ERR), idle_o()});
        tbl.push_back('{mi(0, 0, 0, 1, 32'h500, 32'h88, 32'h9999, ERR), d_o(0, 1, 32'h500, 32'h88, 0, 0, 1)});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, FREE), idle_o()});

        // ---- reset state ----
        drive(mi(0, 0, 0, 0, 0, 0, 0, FREE));
        #1 nRST = 1'b0;
        #3 check("reset_values", idle_o());
        repeat (2) @(posedge CLK);
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].in, tbl[i].ex);

        // ---- asynchronous reset during a data write ----
        v = mi(1, 32'h600, 0, 1, 32'h600, 32'h77, 32'h1234, ACC);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("pre_rst_idle%0d", k), v, idle_o());
            step($sformatf("pre_rst_wr%0d", k), v, d_o(0, 1, 32'h600, 32'h77, 0, 0, 0));
        end
        step("pre_rst_idle3", v, idle_o());
        v.rstate = BUSY;
        drive(v);
        @(negedge CLK);
        check("inflight_wr", d_o(0, 1, 32'h600, 32'h77, 1, 0, 0));
        #2 nRST = 1'b0;
        #1 check("async_rst", idle_o());
        drive(mi(0, 0, 0, 0, 0, 0, 0, FREE));
        @(posedge CLK);
        #1 check("rst_held", idle_o());
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK);
        #1;
        v.rstate = ACC;
        step("post_rst_idle0", v, idle_o());
        step("post_rst_wr0", v, d_o(0, 1, 32'h600, 32'h77, 0, 0, 0));
        step("post_rst_idle1", v, idle_o());
        step("post_rst_wr1", v, d_o(0, 1, 32'h600, 32'h77, 0, 0, 0));
        step("post_rst_quiet", mi(0, 0, 0, 0, 0, 0, 0, FREE), idle_o());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
